mix_columns_iter: RTL and testbench
===================================

Name: mix_columns_iter

Overview:
- Iterative, parametrised AES MixColumns engine with valid/ready handshakes on input and output.
- Processes a 128-bit state COLS_PER_CYCLE columns per clock, so the round datapath can trade area against latency.
- Optionally supports InvMixColumns, selected per transaction.
- Sits between ShiftRows and AddRoundKey in the round pipeline.

Parameters:
- COLS_PER_CYCLE, 1: columns transformed per BUSY cycle. Legal values are 1, 2 and 4; any other value is a compile-time error (generate-time $error).
- NCYC, 4/COLS_PER_CYCLE: derived localparam, not overridable. Number of BUSY cycles.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  engine can accept a state this cycle
- in_state  in  128  state; FIPS-197 byte order, s[r][c] at bits [127-8*(4c+r) -: 8]; column c = bits [127-32c -: 32]
- in_inv  in  1  0 = MixColumns, 1 = InvMixColumns (see Optional Feature)
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  downstream accepts the result
- out_state  out  128  transformed state, same byte order as in_state
- busy  out  1  high in BUSY and DONE

Behaviour:
- Reset (asynchronous, rst=1):
  - FSM goes to IDLE; column counter = 0.
  - out_valid=0, out_state=128'h0, busy=0, latched data and mode cleared.
  - Takes effect immediately, including mid-transaction; any in-flight state is discarded and never emitted.
- FSM states: IDLE, BUSY, DONE.
- in_ready is combinational: 1 in IDLE, or in DONE while out_ready=1. It is 0 in BUSY and in reset.
- Accept = in_valid & in_ready. On accept:
  - latch in_state and in_inv;
  - clear the counter;
  - go to BUSY.
- in_valid while in_ready=0 is ignored. No data is captured, and the source must hold the data.
- BUSY, each cycle:
  - transform columns counter*C .. counter*C+C-1, writing the results into the corresponding out_state columns;
  - counter increments;
  - when counter == NCYC-1, go to DONE next cycle.
- Forward per column (a0..a3 to b0..b3), GF(2^8) with modulus 0x11B:
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00), applied per byte before XOR.
- Inverse per column: coefficients rows {0e,0b,0d,09} rotated the same way. Built from xtime chains: 9=8^1, b=8^2^1, d=8^4^1, e=8^4^2.
- Latency: an accept at edge k gives out_valid=1 after edge k+NCYC.
- Result timing: out_state is fully updated when out_valid rises and is stable while out_valid=1. Columns not yet processed in BUSY are undefined to the consumer.
- DONE: out_valid=1 and held until out_ready=1. On handshake:
  - if in_valid=1 in the same cycle, accept the new state and go to BUSY (back-to-back, no bubble on input);
  - otherwise go to IDLE with out_valid=0.
- Sustained throughput: one state per NCYC+1 cycles with out_ready held at 1.
- out_ready while out_valid=0 is ignored.

Optional Feature:
- Macro: MIX_COLUMNS_INV_EN.
- Defined: in_inv is latched and selects InvMixColumns per transaction.
- Undefined:
  - in_inv is ignored, inverse datapath is not synthesised, forward transform always.
  - Test scenario 3 below returns the forward result in this configuration.

Test Plan:
1. C=1: accept in_state=db135345_f20a225c_01010101_2d26314c, in_inv=0, out_ready=1 -> out_valid rises exactly 4 cycles after accept; out_state=8e4da1bc_9fdc589d_01010101_4d7ebdf8; in_ready low for those 4 cycles.
2. C=4 and C=2, same vector -> identical out_state, out_valid after 1 and 2 cycles respectively.
3. MIX_COLUMNS_INV_EN defined: in_state=8e4da1bc_9fdc589d_01010101_4d7ebdf8, in_inv=1 -> out_state=db135345_f20a225c_01010101_2d26314c. Also check c6c6c6c6 and d4d4d4d5 columns round-trip forward/inverse (forward d4d4d4d5 -> d5d5d7d6).
4. Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid and out_state stable and in_ready=0. Then out_ready=1 with in_valid=1 and a new vector -> same-cycle accept, next result correct after NCYC cycles.
5. Reset mid-BUSY (C=1, assert rst on 2nd BUSY cycle) -> out_valid=0, out_state=0, busy=0 immediately. After release, in_ready=1 and a fresh transaction completes correctly with no stale output.
6. in_valid pulsed during BUSY with a different vector -> ignored; the result matches the originally accepted state.

Source files
------------

// File: rtl/mix_columns_iter_if.sv
// mix_columns_iter_if: handshake and data bundle for the iterative MixColumns engine.
// Ports: in_valid/in_ready/in_state/in_inv (input side), out_valid/out_ready/out_state
//        (output side), busy (status). slave = engine side, master = driver/consumer side.
interface mix_columns_iter_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_state;
  logic         in_inv;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_state;
  logic         busy;

  modport master (
    output in_valid, in_state, in_inv, out_ready,
    input  in_ready, out_valid, out_state, busy
  );

  modport slave (
    input  in_valid, in_state, in_inv, out_ready,
    output in_ready, out_valid, out_state, busy
  );
endinterface

// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative AES MixColumns (optionally InvMixColumns), COLS_PER_CYCLE columns/clk.
// Latency: accept at edge k -> out_valid after edge k+NCYC (NCYC = 4/COLS_PER_CYCLE); back-to-back
//          accepts in DONE give one state per NCYC+1 cycles. Backpressure: result held until out_ready.
// Ports: clk, rst (async active-high), bus (mix_columns_iter_if.slave): in_valid/in_ready/in_state/
//        in_inv, out_valid/out_ready/out_state, busy. Byte order: column c = bits [127-32c -: 32],
//        row r of a column at bits [31-8r -: 8]. Optional macro MIX_COLUMNS_INV_EN enables the
//        per-transaction inverse transform; without it in_inv is ignored and only forward is built.
module mix_columns_iter #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  mix_columns_iter_if.slave bus
);

  localparam int NCYC = 4 / COLS_PER_CYCLE;
  localparam logic [1:0] LAST_CNT = 2'(NCYC - 1);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
    $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // ---------------------------------------------------------------------------
  // GF(2^8) helpers, modulus 0x11B
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Columns are {row0, row1, row2, row3} from MSB to LSB.
  function automatic logic [31:0] mix_fwd(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return { xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3) };
  endfunction

`ifdef MIX_COLUMNS_INV_EN
  // Returns {0e*a, 0b*a, 0d*a, 09*a}, sharing one xtime chain (x2, x4, x8).
  function automatic logic [31:0] inv_mul(input logic [7:0] a);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return {x8 ^ x4 ^ x2, x8 ^ x2 ^ a, x8 ^ x4 ^ a, x8 ^ a};
  endfunction

  function automatic logic [31:0] mix_inv(input logic [31:0] c);
    logic [31:0] p0, p1, p2, p3;  // per-row products {e, b, d, 9}
    p0 = inv_mul(c[31:24]);
    p1 = inv_mul(c[23:16]);
    p2 = inv_mul(c[15:8]);
    p3 = inv_mul(c[7:0]);
    // Field layout of p*: [31:24]=e, [23:16]=b, [15:8]=d, [7:0]=9
    return { p0[31:24] ^ p1[23:16] ^ p2[15:8]  ^ p3[7:0],
             p0[7:0]   ^ p1[31:24] ^ p2[23:16] ^ p3[15:8],
             p0[15:8]  ^ p1[7:0]   ^ p2[31:24] ^ p3[23:16],
             p0[23:16] ^ p1[15:8]  ^ p2[7:0]   ^ p3[31:24] };
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [1:0]       cnt_q;
  logic [3:0][31:0] data_q;       // latched input; element 3 is column 0
  logic [3:0][31:0] out_q;        // result; element 3 is column 0
  logic [3:0][31:0] out_d;
  logic             inv_q;
  logic             inv_d;
  logic             out_valid_q;
  logic             busy_q;
  logic             in_ready_w;
  logic             accept;
  logic [1:0]       col_sel;

`ifdef MIX_COLUMNS_INV_EN
  assign inv_d = bus.in_inv;
`else
  // Mode is never used in a forward-only build; keep it tied off.
  assign inv_d = 1'b0;
  logic unused_inv;
  assign unused_inv = bus.in_inv ^ inv_q;
`endif

  // Ready is combinational so DONE can hand off and accept on the same edge.
  assign in_ready_w = ~rst & ((state_q == ST_IDLE) |
                              ((state_q == ST_DONE) & bus.out_ready));
  assign accept     = bus.in_valid & in_ready_w;

  // ---------------------------------------------------------------------------
  // Column datapath: COLS_PER_CYCLE copies of the column transform, each
  // steered to column cnt_q*COLS_PER_CYCLE + j.
  // ---------------------------------------------------------------------------
  always_comb begin
    out_d   = out_q;
    col_sel = 2'd0;
    for (int j = 0; j < COLS_PER_CYCLE; j++) begin
      col_sel = 2'(int'(cnt_q) * COLS_PER_CYCLE + j);
`ifdef MIX_COLUMNS_INV_EN
      out_d[2'd3 - col_sel] = inv_q ? mix_inv(data_q[2'd3 - col_sel])
                                    : mix_fwd(data_q[2'd3 - col_sel]);
`else
      out_d[2'd3 - col_sel] = mix_fwd(data_q[2'd3 - col_sel]);
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      data_q      <= '0;
      inv_q       <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            data_q  <= bus.in_state;
            inv_q   <= inv_d;
            cnt_q   <= 2'd0;
            busy_q  <= 1'b1;
            state_q <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          out_q <= out_d;
          cnt_q <= cnt_q + 2'd1;
          if (cnt_q == LAST_CNT) begin
            out_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end
        end

        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (bus.in_valid) begin
              // Back-to-back: result handed off and next state taken on one edge.
              data_q  <= bus.in_state;
              inv_q   <= inv_d;
              cnt_q   <= 2'd0;
              state_q <= ST_BUSY;
            end else begin
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
        end

        default: begin
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_w;
  assign bus.out_valid = out_valid_q;
  assign bus.out_state = out_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
// tb_mix_columns_iter: directed bench for mix_columns_iter at COLS_PER_CYCLE = 1, 2 and 4.
// Expected states come from a generic GF(2^8) matrix model or fixed vectors and are queued
// at accept time, then popped and compared when out_valid rises.
`timescale 1ns/1ps
module tb_mix_columns_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         in_valid  [3];
  logic         out_ready [3];
  logic [127:0] in_state;
  logic         in_inv;

  logic         ov [3];
  logic         ir [3];
  logic         bz [3];
  logic [127:0] os [3];

  mix_columns_iter_if if_c1 ();
  mix_columns_iter_if if_c2 ();
  mix_columns_iter_if if_c4 ();

  mix_columns_iter #(.COLS_PER_CYCLE(1)) u_c1 (.clk(clk), .rst(rst), .bus(if_c1));
  mix_columns_iter #(.COLS_PER_CYCLE(2)) u_c2 (.clk(clk), .rst(rst), .bus(if_c2));
  mix_columns_iter #(.COLS_PER_CYCLE(4)) u_c4 (.clk(clk), .rst(rst), .bus(if_c4));

  assign if_c1.in_valid  = in_valid[0];
  assign if_c2.in_valid  = in_valid[1];
  assign if_c4.in_valid  = in_valid[2];
  assign if_c1.out_ready = out_ready[0];
  assign if_c2.out_ready = out_ready[1];
  assign if_c4.out_ready = out_ready[2];
  assign if_c1.in_state  = in_state;
  assign if_c2.in_state  = in_state;
  assign if_c4.in_state  = in_state;
  assign if_c1.in_inv    = in_inv;
  assign if_c2.in_inv    = in_inv;
  assign if_c4.in_inv    = in_inv;

  assign ov[0] = if_c1.out_valid;  assign ov[1] = if_c2.out_valid;  assign ov[2] = if_c4.out_valid;
  assign ir[0] = if_c1.in_ready;   assign ir[1] = if_c2.in_ready;   assign ir[2] = if_c4.in_ready;
  assign bz[0] = if_c1.busy;       assign bz[1] = if_c2.busy;       assign bz[2] = if_c4.busy;
  assign os[0] = if_c1.out_state;  assign os[1] = if_c2.out_state;  assign os[2] = if_c4.out_state;

`ifdef MIX_COLUMNS_INV_EN
  localparam bit INV_EN = 1'b1;
`else
  localparam bit INV_EN = 1'b0;
`endif

  localparam int NCYC_OF [3] = '{4, 2, 1};

  int tests = 0;
  int fails = 0;
  logic [127:0] sb [$];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
    end
    return p;
  endfunction

  function automatic logic [31:0] model_col(input logic [31:0] c, input logic inv);
    logic [7:0]  m [4];
    logic [7:0]  a [4];
    logic [7:0]  b;
    logic [31:0] r;
    if (inv) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else     m = '{8'h02, 8'h03, 8'h01, 8'h01};
    for (int i = 0; i < 4; i++) a[i] = c[31-8*i -: 8];
    r = 32'h0;
    for (int rr = 0; rr < 4; rr++) begin
      b = 8'h00;
      for (int cc = 0; cc < 4; cc++) b = b ^ gmul(m[(cc - rr + 4) % 4], a[cc]);
      r[31-8*rr -: 8] = b;
    end
    return r;
  endfunction

  function automatic logic [127:0] model_state(input logic [127:0] s, input logic inv);
    logic [127:0] r;
    for (int c = 0; c < 4; c++) r[127-32*c -: 32] = model_col(s[127-32*c -: 32], inv & INV_EN);
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a state, wait (bounded) for in_ready, queue expectation; returns just after accept edge.
  task automatic send(input int d, input logic [127:0] s, input logic inv,
                      input logic [127:0] exp, output int waited);
    int n;
    n = 0;
    in_state    = s;
    in_inv      = inv;
    in_valid[d] = 1'b1;
    #1;
    while (ir[d] !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    check("accept_ready", {127'h0, ir[d]}, 128'h1);
    sb.push_back(exp);
    tick();
    in_valid[d] = 1'b0;
    waited = n;
  endtask

  // Wait for out_valid, check latency, in_ready low while busy, and result; consume if out_ready.
  task automatic expect_result(input int d, input int lat, input string tag);
    int n;
    bit rdy_seen;
    logic [127:0] exp;
    n = 0;
    rdy_seen = 1'b0;
    while (ov[d] !== 1'b1 && n < 100) begin
      if (ir[d] !== 1'b0) rdy_seen = 1'b1;
      tick();
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'(lat));
    check({tag, "_in_ready_busy"}, {127'h0, rdy_seen}, 128'h0);
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $error("FAIL %s_queue: observed empty expected one entry", tag);
      exp = '0;
    end else begin
      exp = sb.pop_front();
    end
    check({tag, "_state"}, os[d], exp);
    check({tag, "_busy"}, {127'h0, bz[d]}, 128'h1);
    if (out_ready[d] === 1'b1) begin
      tick();
      check({tag, "_released"}, {127'h0, ov[d]}, 128'h0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] va, vb, vc, vr, exp_a;
    logic         rinv;
    int           w;

    rst = 1'b1;
    in_state = '0;
    in_inv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid[i]  = 1'b0;
      out_ready[i] = 1'b1;
    end
    #1;
    for (int i = 0; i < 3; i++) begin
      check("rst_out_valid", {127'h0, ov[i]}, 128'h0);
      check("rst_out_state", os[i], 128'h0);
      check("rst_busy", {127'h0, bz[i]}, 128'h0);
      check("rst_in_ready", {127'h0, ir[i]}, 128'h0);
    end
    tick();
    tick();
    rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) check("idle_in_ready", {127'h0, ir[i]}, 128'h1);

    va = 128'hdb135345_f20a225c_01010101_2d26314c;
    vb = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;

    // 1: C=1 known vector
    send(0, va, 1'b0, vb, w);
    expect_result(0, 4, "c1_fips");

    // 2: C=2 and C=4, same vector
    send(1, va, 1'b0, vb, w);
    expect_result(1, 2, "c2_fips");
    send(2, va, 1'b0, vb, w);
    expect_result(2, 1, "c4_fips");

    // 3: fixed columns forward, then inverse / round trip
    vc = 128'hd4d4d4d5_c6c6c6c6_01010101_f20a225c;
    vr = 128'hd5d5d7d6_c6c6c6c6_01010101_9fdc589d;
    send(0, vc, 1'b0, vr, w);
    expect_result(0, 4, "c1_cols_fwd");
`ifdef MIX_COLUMNS_INV_EN
    send(0, vb, 1'b1, va, w);
    expect_result(0, 4, "c1_inv_fips");
    send(0, vr, 1'b1, vc, w);
    expect_result(0, 4, "c1_cols_inv");
`else
    send(0, vb, 1'b1, model_state(vb, 1'b1), w);
    expect_result(0, 4, "c1_inv_ignored");
    send(0, vr, 1'b1, model_state(vr, 1'b1), w);
    expect_result(0, 4, "c1_cols_inv_ignored");
`endif
    send(2, vr, 1'b1, model_state(vr, 1'b1), w);
    expect_result(2, 1, "c4_cols_inv");

    // 4: backpressure then same-cycle handoff
    out_ready[0] = 1'b0;
    send(0, vc, 1'b0, vr, w);
    w = 0;
    while (ov[0] !== 1'b1 && w < 100) begin
      tick();
      w++;
    end
    check("bp_latency", 128'(w), 128'd4);
    exp_a = (sb.size() != 0) ? sb.pop_front() : 128'h0;
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", {127'h0, ov[0]}, 128'h1);
      check("bp_out_state", os[0], exp_a);
      check("bp_in_ready", {127'h0, ir[0]}, 128'h0);
      tick();
    end
    out_ready[0] = 1'b1;
    send(0, va, 1'b0, vb, w);
    check("b2b_no_wait", 128'(w), 128'd0);
    check("b2b_out_valid_drop", {127'h0, ov[0]}, 128'h0);
    check("b2b_busy", {127'h0, bz[0]}, 128'h1);
    expect_result(0, 4, "b2b_next");

    // 5: reset during second BUSY cycle
    send(0, vc, 1'b0, vr, w);
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {127'h0, ov[0]}, 128'h0);
    check("mid_rst_out_state", os[0], 128'h0);
    check("mid_rst_busy", {127'h0, bz[0]}, 128'h0);
    check("mid_rst_in_ready", {127'h0, ir[0]}, 128'h0);
    sb.delete();
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", {127'h0, ir[0]}, 128'h1);
    check("post_rst_out_valid", {127'h0, ov[0]}, 128'h0);
    vc = {$urandom, $urandom, $urandom, $urandom};
    send(0, vc, 1'b0, model_state(vc, 1'b0), w);
    expect_result(0, 4, "post_rst_fresh");

    // 6: in_valid pulse during BUSY is ignored
    send(0, va, 1'b0, vb, w);
    in_state    = 128'hffeeddcc_bbaa9988_77665544_33221100;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    expect_result(0, 3, "busy_pulse_ignored");

    // Random vectors, random mode, every width
    for (int k = 0; k < 6; k++) begin
      int d;
      d    = k % 3;
      vc   = {$urandom, $urandom, $urandom, $urandom};
      rinv = 1'($urandom_range(0, 1));
      send(d, vc, rinv, model_state(vc, rinv), w);
      expect_result(d, NCYC_OF[d], "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
